// File: rtl/seg_scan_ctrl_pkg.sv
// Shared definitions for the seven-segment scan controller: blank pattern,
// hex-to-segment table (active-low {g,f,e,d,c,b,a}) and FSM state codes.
// Optional feature macro used by seg_scan_ctrl: SEG_LZB_EN (leading-zero blanking).
package seg_scan_ctrl_pkg;

    // All segments off (active-low)
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Active-low segment patterns for nibbles 0..F
    localparam logic [6:0] HEX_SEG [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30,
        7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03,
        7'h46, 7'h21, 7'h06, 7'h0E
    };

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_DRIVE = 1'b1
    } scan_state_e;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/seg_scan_ctrl_if.sv
// Display-word write channel: valid/ready handshake carrying one hex nibble
// and one decimal-point bit per digit.
interface seg_scan_ctrl_if #(
    parameter int unsigned NUM_DIGITS = 4
);
    logic                    wr_valid;
    logic                    wr_ready;
    logic [4*NUM_DIGITS-1:0] wr_data;
    logic [NUM_DIGITS-1:0]   wr_dp;

    // Digit writer side
    modport master (
        output wr_valid,
        output wr_data,
        output wr_dp,
        input  wr_ready
    );

    // Scan controller side
    modport slave (
        input  wr_valid,
        input  wr_data,
        input  wr_dp,
        output wr_ready
    );
endinterface

// File: rtl/seg_scan_ctrl_hex_decode.sv
// Combinational nibble to seven-segment decoder, active-low {g,f,e,d,c,b,a}.
module seg_hex_decode
    import seg_scan_ctrl_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg_n
);

    // Table lookup of the segment pattern
    always_comb begin
        seg_n = HEX_SEG[nibble];
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Seven-segment bus scheduler: drives one digit at a time with a dead-time
// blank before each digit, and double-buffers display words so a frame is
// always drawn from a single word. New words land in a pending buffer and
// move to the active buffer only on the frame wrap.
// Optional: define SEG_LZB_EN for leading-zero blanking of digits above 0.
module seg_scan_ctrl
    import seg_scan_ctrl_pkg::*;
#(
    parameter int unsigned NUM_DIGITS   = 4,
    parameter int unsigned DIGIT_HOLD   = 12500,
    parameter int unsigned BLANK_CYCLES = 500
) (
    input  logic                  clk,
    input  logic                  rst,
    seg_scan_ctrl_if.slave        wr,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic [NUM_DIGITS-1:0] an,
    output logic                  frame_done
);

    localparam int unsigned CNT_W = $clog2(max_u(DIGIT_HOLD, BLANK_CYCLES) + 1);
    localparam int unsigned IDX_W = $clog2(NUM_DIGITS);

    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(DIGIT_HOLD - 1);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

    scan_state_e             state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [4*NUM_DIGITS-1:0] pend_data_q, pend_data_d;
    logic [NUM_DIGITS-1:0]   pend_dp_q, pend_dp_d;
    logic                    pend_full_q, pend_full_d;
    logic [4*NUM_DIGITS-1:0] act_data_q, act_data_d;
    logic [NUM_DIGITS-1:0]   act_dp_q, act_dp_d;
    logic [6:0]              seg_q, seg_d;
    logic                    dp_q, dp_d;
    logic [NUM_DIGITS-1:0]   an_q, an_d;
    logic                    frame_done_q, frame_done_d;

    logic [3:0]              dec_nibble;
    logic [6:0]              dec_seg;
    logic [NUM_DIGITS-1:0]   lzb_mask;

    // Writer may hand over a word whenever the pending buffer is empty
    always_comb begin
        wr.wr_ready = ~pend_full_q;
    end

    // Select the nibble of the digit that will be driven after this edge
    always_comb begin
        dec_nibble = act_data_q[{idx_d, 2'b00} +: 4];
    end

    seg_hex_decode u_hex_decode (
        .nibble (dec_nibble),
        .seg_n  (dec_seg)
    );

`ifdef SEG_LZB_EN
    // Blank digit i>0 when it and every higher digit hold 0 with dp clear
    always_comb begin
        logic zero_run;
        lzb_mask = '0;
        zero_run = 1'b1;
        for (int unsigned i = NUM_DIGITS - 1; i >= 1; i--) begin
            zero_run    = zero_run & (act_data_q[4*i +: 4] == 4'h0) & ~act_dp_q[i];
            lzb_mask[i] = zero_run;
        end
    end
`else
    // Every digit always shows its nibble
    always_comb begin
        lzb_mask = '0;
    end
`endif

    // Scan FSM, digit index, frame wrap and double-buffer management
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q + CNT_W'(1);
        idx_d        = idx_q;
        frame_done_d = 1'b0;
        pend_data_d  = pend_data_q;
        pend_dp_d    = pend_dp_q;
        pend_full_d  = pend_full_q;
        act_data_d   = act_data_q;
        act_dp_d     = act_dp_q;

        unique case (state_q)
            ST_BLANK: begin
                if (cnt_q == BLANK_LAST) begin
                    state_d = ST_DRIVE;
                    cnt_d   = '0;
                end
            end
            ST_DRIVE: begin
                if (cnt_q == HOLD_LAST) begin
                    state_d = ST_BLANK;
                    cnt_d   = '0;
                    if (idx_q == IDX_LAST) begin
                        idx_d        = '0;
                        frame_done_d = 1'b1;
                        if (pend_full_q) begin
                            act_data_d  = pend_data_q;
                            act_dp_d    = pend_dp_q;
                            pend_full_d = 1'b0;
                        end
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
        endcase

        // Capture only when empty, so this never collides with the wrap copy above
        if (wr.wr_valid && !pend_full_q) begin
            pend_data_d = wr.wr_data;
            pend_dp_d   = wr.wr_dp;
            pend_full_d = 1'b1;
        end
    end

    // Output pins follow the next state so they switch on the transition edge
    always_comb begin
        an_d  = '1;
        seg_d = SEG_BLANK;
        dp_d  = 1'b1;
        if (state_d == ST_DRIVE) begin
            an_d[idx_d] = 1'b0;
            if (!lzb_mask[idx_d]) begin
                seg_d = dec_seg;
                dp_d  = ~act_dp_q[idx_d];
            end
        end
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_BLANK;
            cnt_q        <= '0;
            idx_q        <= '0;
            pend_data_q  <= '0;
            pend_dp_q    <= '0;
            pend_full_q  <= 1'b0;
            act_data_q   <= '0;
            act_dp_q     <= '0;
            seg_q        <= SEG_BLANK;
            dp_q         <= 1'b1;
            an_q         <= '1;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            pend_data_q  <= pend_data_d;
            pend_dp_q    <= pend_dp_d;
            pend_full_q  <= pend_full_d;
            act_data_q   <= act_data_d;
            act_dp_q     <= act_dp_d;
            seg_q        <= seg_d;
            dp_q         <= dp_d;
            an_q         <= an_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign seg        = seg_q;
    assign dp         = dp_q;
    assign an         = an_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl (NUM_DIGITS=4, DIGIT_HOLD=8, BLANK_CYCLES=2).
// Offered words are queued; accepted words are pushed to a pending scoreboard
// queue and popped into the expected display at each frame wrap.
// Expectations follow SEG_LZB_EN when it is defined.
module tb_seg_scan_ctrl;

    localparam int ND     = 4;
    localparam int HOLD   = 8;
    localparam int BLK    = 2;
    localparam int PERIOD = HOLD + BLK;
    localparam int FRAME  = ND * PERIOD;

    typedef struct packed {
        logic [15:0] data;
        logic [3:0]  dps;
    } word_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [6:0] seg;
    logic       dp;
    logic [3:0] an;
    logic       frame_done;

    always #5 clk = ~clk;

    seg_scan_ctrl_if #(.NUM_DIGITS(ND)) wr_if ();

    seg_scan_ctrl #(
        .NUM_DIGITS   (ND),
        .DIGIT_HOLD   (HOLD),
        .BLANK_CYCLES (BLK)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .wr         (wr_if),
        .seg        (seg),
        .dp         (dp),
        .an         (an),
        .frame_done (frame_done)
    );

    word_t       stim_q[$];
    word_t       pend_q[$];
    word_t       active_m = '0;
    int          errors   = 0;
    int          checks   = 0;
    bit          hold_mode = 1'b0;
    logic [15:0] hold_word = 16'h0000;
    int          captures;

    function automatic logic [6:0] hex7(input logic [3:0] n);
        case (n)
            4'h0: return 7'h40;  4'h1: return 7'h79;
            4'h2: return 7'h24;  4'h3: return 7'h30;
            4'h4: return 7'h19;  4'h5: return 7'h12;
            4'h6: return 7'h02;  4'h7: return 7'h78;
            4'h8: return 7'h00;  4'h9: return 7'h10;
            4'hA: return 7'h08;  4'hB: return 7'h03;
            4'hC: return 7'h46;  4'hD: return 7'h21;
            4'hE: return 7'h06;  default: return 7'h0E;
        endcase
    endfunction

    function automatic bit lzb(input word_t w, input int d);
`ifdef SEG_LZB_EN
        if (d == 0) return 1'b0;
        for (int j = d; j < ND; j++) begin
            if (w.data[4*j +: 4] != 4'h0 || w.dps[j]) return 1'b0;
        end
        return 1'b1;
`else
        return (d < 0);
`endif
    endfunction

    // Expected {an, seg, dp, frame_done, wr_ready} at position p of a frame
    function automatic logic [13:0] expect_at(input int p, input bit fd_first,
                                              input word_t w, input bit rdy);
        int         d     = p / PERIOD;
        int         r     = p % PERIOD;
        logic [3:0] an_e  = 4'hF;
        logic [6:0] seg_e = 7'h7F;
        logic       dp_e  = 1'b1;
        if (r >= BLK) begin
            an_e[d] = 1'b0;
            if (!lzb(w, d)) begin
                seg_e = hex7(w.data[4*d +: 4]);
                dp_e  = ~w.dps[d];
            end
        end
        return {an_e, seg_e, dp_e, (p == 0) && fd_first, rdy};
    endfunction

    task automatic check(input string tag, input logic [13:0] obs, input logic [13:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic offer(input logic [15:0] d, input logic [3:0] p);
        word_t w;
        w.data = d;
        w.dps  = p;
        stim_q.push_back(w);
    endtask

    // Walk one frame from its first blank cycle; optional reset at abort_p
    task automatic run_frame(input bit fd_first, input int abort_p, input string name);
        word_t shown = active_m;
        captures = 0;
        for (int p = 0; p < FRAME; p++) begin
            bit acc;
            check($sformatf("%s p%0d", name, p),
                  {an, seg, dp, frame_done, wr_if.wr_ready},
                  expect_at(p, fd_first, shown, pend_q.size() == 0));
            if (p == abort_p) begin
                rst            = 1'b1;
                wr_if.wr_valid = 1'b0;
                stim_q.delete();
                tick();
                pend_q.delete();
                active_m = '0;
                rst      = 1'b0;
                return;
            end
            if (hold_mode && stim_q.size() == 0) begin
                hold_word++;
                offer(hold_word, 4'h0);
            end
            if (stim_q.size() > 0) begin
                wr_if.wr_valid = 1'b1;
                wr_if.wr_data  = stim_q[0].data;
                wr_if.wr_dp    = stim_q[0].dps;
            end else begin
                wr_if.wr_valid = 1'b0;
            end
            acc = (stim_q.size() > 0) && (pend_q.size() == 0);
            tick();
            if (p == FRAME - 1 && pend_q.size() > 0) active_m = pend_q.pop_front();
            if (acc) begin
                pend_q.push_back(stim_q.pop_front());
                captures++;
            end
        end
        if (hold_mode) check($sformatf("%s captures", name), 14'(captures), 14'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset held 3 cycles; a write offered during reset must be ignored
        rst            = 1'b1;
        wr_if.wr_valid = 1'b1;
        wr_if.wr_data  = 16'hFFFF;
        wr_if.wr_dp    = 4'hF;
        repeat (3) tick();
        check("reset outputs", {an, seg, dp, frame_done, 1'b0}, {4'hF, 7'h7F, 1'b1, 1'b0, 1'b0});
        rst            = 1'b0;
        wr_if.wr_valid = 1'b0;

        // Basic word: shown from the frame after acceptance
        offer(16'h1234, 4'h0);
        run_frame(1'b0, -1, "f0");
        // Two words in one frame: A then B, never mixed
        offer(16'h89AB, 4'b1010);
        offer(16'hCDEF, 4'b0101);
        run_frame(1'b1, -1, "f1");
        run_frame(1'b1, -1, "f2");
        offer(16'h5670, 4'h0);
        run_frame(1'b1, -1, "f3");
        // Pending word is discarded by a reset during digit 2 drive
        offer(16'h1111, 4'hF);
        run_frame(1'b1, 2 * PERIOD + BLK + 3, "f4");
        run_frame(1'b0, -1, "r0");
        // Leading-zero cases
        offer(16'h0045, 4'h0);
        run_frame(1'b1, -1, "r1");
        offer(16'h0000, 4'h0);
        run_frame(1'b1, -1, "z1");
        offer(16'h0045, 4'b0100);
        run_frame(1'b1, -1, "z2");
        offer(16'h0405, 4'h0);
        run_frame(1'b1, -1, "z3");
        run_frame(1'b1, -1, "z4");
        // Valid held high: one capture per frame
        hold_mode = 1'b1;
        run_frame(1'b1, -1, "h1");
        run_frame(1'b1, -1, "h2");
        run_frame(1'b1, -1, "h3");
        hold_mode = 1'b0;
        stim_q.delete();
        run_frame(1'b1, -1, "h4");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
